// File: rtl/v_hier_subsub_arb.sv
// Round-robin arbiter that time-shares one 1-bit signed pass-through stage
// (v_hier_subsub) between NREQ requesters, with bounded bursts per grant.

module v_hier_subsub (
    input  logic signed [0:0] a,
    output logic signed [0:0] y
);
    assign y = a;
endmodule

module v_hier_subsub_arb #(
    parameter int NREQ = 4,
    parameter int SRCW = 2,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic            q,
    output logic            q_valid,
    output logic [SRCW-1:0] q_src
);
    localparam int CW = 5;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                state;
    logic [SRCW-1:0]       ptr;
    logic [CW-1:0]         count;

    logic                  any_req;
    logic                  found;
    logic [SRCW-1:0]       winner;
    logic [SRCW:0]         start;
    logic [2*NREQ-1:0]     rot;
    logic                  xfer;
    logic                  release_g;
    logic signed [0:0]     stage_in;
    logic signed [0:0]     stage_out;

    // ptr always names the current grantee, so it doubles as the mux select
    assign stage_in = din[ptr];

    v_hier_subsub u_subsub (
        .a (stage_in),
        .y (stage_out)
    );

    assign any_req   = |req;
    assign xfer      = (state == GRANT) && req[ptr];
    assign release_g = (state == GRANT) &&
                       (!req[ptr] || (count == CW'(HOLD - 1)));

    // Rotate req so bit 0 is the requester just after ptr; ptr itself lands last
    always_comb begin
        int off;
        start  = {1'b0, ptr} + 1'b1;
        rot    = {req, req} >> start;
        winner = ptr;
        found  = 1'b0;
        off    = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = int'(start) + j;
                if (off >= NREQ) begin
                    off = off - NREQ;
                end
                winner = SRCW'(off);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= SRCW'(NREQ - 1);
            count   <= '0;
            gnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            q_src   <= '0;
        end else begin
            q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= NREQ'(1) << winner;
                        ptr   <= winner;
                        count <= '0;
                        state <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        q       <= stage_out;
                        q_valid <= 1'b1;
                        q_src   <= ptr;
                        count   <= count + 1'b1;
                    end
                    // Handoff happens on the releasing edge so there is no idle bubble
                    if (release_g) begin
                        if (any_req) begin
                            gnt   <= NREQ'(1) << winner;
                            ptr   <= winner;
                            count <= '0;
                        end else begin
                            gnt   <= '0;
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end
endmodule
